// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack sequencer: direction encoding, flag bit
// positions, SP defaults, FSM state type and the frame address helper.
package stack_sequencer_pkg;

    localparam logic PUSH = 1'b1;
    localparam logic POP  = 1'b0;

    localparam int STK_FLG_Z  = 0;
    localparam int STK_FLG_C  = 1;
    localparam int STK_FLG_N  = 2;
    localparam int STK_FLG_V  = 3;
    localparam int STK_FLG_IF = 4;
    localparam int STK_FLG_IE = 5;

    localparam logic [7:0] SP_INIT_DEF  = 8'hFF;
    localparam logic [7:0] SP_LIMIT_DEF = 8'hC0;

    typedef enum logic {
        S_ACC0 = 1'b0,
        S_ACC1 = 1'b1
    } stk_state_t;

    // Push: PC at sp, flags at sp-1. Pop: flags at sp+1, PC at sp+2.
    function automatic logic [7:0] frame_addr(input logic [7:0] sp_val,
                                              input logic       dir,
                                              input logic       second);
        if (dir == PUSH)
            return second ? (sp_val - 8'd1) : sp_val;
        else
            return second ? (sp_val + 8'd2) : (sp_val + 8'd1);
    endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Controller/data-memory side of the stack sequencer: frame request,
// bus handshake, push payload, access address/data and popped values.
interface stack_sequencer_if;
    logic       stack_op_ongoing;
    logic       push_or_pop;
    logic       bus_grant;
    logic [7:0] pc_in;
    logic [5:0] flags_in;
    logic [7:0] mem_din;
    logic [7:0] stack_addr;
    logic [7:0] stack_wdata;
    logic       stack_op_end;
    logic [7:0] pc_pop;
    logic [5:0] flags_pop;

    modport master (
        output stack_op_ongoing, push_or_pop, bus_grant, pc_in, flags_in, mem_din,
        input  stack_addr, stack_wdata, stack_op_end, pc_pop, flags_pop
    );

    modport slave (
        input  stack_op_ongoing, push_or_pop, bus_grant, pc_in, flags_in, mem_din,
        output stack_addr, stack_wdata, stack_op_end, pc_pop, flags_pop
    );
endinterface

// File: rtl/stack_sequencer.sv
// Two-access stack frame engine (PC + flags) owning SP; addresses are combinational,
// popped values registered. Each access waits for bus_grant; no internal buffering.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter logic [7:0] SP_INIT  = SP_INIT_DEF,
    parameter logic [7:0] SP_LIMIT = SP_LIMIT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    stack_sequencer_if.slave        bus,
    input  logic                    dbg_is_brk,
    input  logic                    dbg_sp_wr,
    input  logic [7:0]              dbg_sp_din,
    output logic [7:0]              sp,
    output logic                    stack_ovf,
    output logic                    stack_unf
);

    stk_state_t state_q, state_d;
    logic       dir_q;
    logic [7:0] sp_q;
    logic       ovf_q, unf_q;
    logic [7:0] pc_pop_q;
    logic [5:0] flags_pop_q;

    logic       cur_dir;
    logic       first_grant;
    logic       last_grant;
    logic       dbg_load;
    logic       ovf_hit;
    logic       unf_hit;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_ACC0;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        cur_dir          = (state_q == S_ACC1) ? dir_q : bus.push_or_pop;
        first_grant      = 1'b0;
        last_grant       = 1'b0;
        bus.stack_wdata  = 8'h00;
        bus.stack_addr   = frame_addr(sp_q, cur_dir, state_q == S_ACC1);

        case (state_q)
            S_ACC0: begin
                if (bus.stack_op_ongoing && bus.bus_grant) begin
                    first_grant = 1'b1;
                    state_d     = S_ACC1;
                end
            end
            S_ACC1: begin
                // A dropped request mid-frame abandons the frame without ending it.
                if (!bus.stack_op_ongoing) begin
                    state_d = S_ACC0;
                end else if (bus.bus_grant) begin
                    last_grant = 1'b1;
                    state_d    = S_ACC0;
                end
            end
            default: state_d = S_ACC0;
        endcase

        if (cur_dir == PUSH)
            bus.stack_wdata = (state_q == S_ACC1) ? {2'b00, bus.flags_in} : bus.pc_in;

        bus.stack_op_end = last_grant;
    end

    // Limit checks use unwrapped values so sp=00 overflows and sp=FE/FF underflows.
    assign ovf_hit  = (bus.push_or_pop == PUSH) && (sp_q <= SP_LIMIT);
    assign unf_hit  = (bus.push_or_pop == POP) && (({1'b0, sp_q} + 9'd2) > {1'b0, SP_INIT});
    assign dbg_load = dbg_is_brk && dbg_sp_wr && (state_q == S_ACC0);

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q       <= POP;
            sp_q        <= SP_INIT;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            pc_pop_q    <= 8'h00;
            flags_pop_q <= 6'h00;
        end else begin
            if (first_grant) begin
                dir_q <= bus.push_or_pop;
                if (bus.push_or_pop == POP)
                    flags_pop_q <= bus.mem_din[5:0];
            end
            if (last_grant) begin
                if (dir_q == POP) begin
                    pc_pop_q <= bus.mem_din;
                    sp_q     <= sp_q + 8'd2;
                end else begin
                    sp_q     <= sp_q - 8'd2;
                end
            end
            if (dbg_load) begin
                sp_q  <= dbg_sp_din;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else if (first_grant) begin
                ovf_q <= ovf_q | ovf_hit;
                unf_q <= unf_q | unf_hit;
            end
        end
    end

    assign bus.pc_pop    = pc_pop_q;
    assign bus.flags_pop = flags_pop_q;
    assign sp            = sp_q;
    assign stack_ovf     = ovf_q;
    assign stack_unf     = unf_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized frame traffic against a byte-array stack model with integer SP arithmetic.
module tb_stack_sequencer;
    import stack_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dbg_is_brk = 1'b0;
    logic       dbg_sp_wr = 1'b0;
    logic [7:0] dbg_sp_din = 8'h00;
    logic [7:0] sp;
    logic       stack_ovf, stack_unf;

    stack_sequencer_if bus();

    stack_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dbg_is_brk (dbg_is_brk),
        .dbg_sp_wr  (dbg_sp_wr),
        .dbg_sp_din (dbg_sp_din),
        .sp         (sp),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_sp;
    bit         m_ovf, m_unf;
    logic [7:0] m_pc_pop;
    logic [5:0] m_flags_pop;
    logic [7:0] mem [256];

    task automatic idle_inputs();
        bus.stack_op_ongoing = 1'b0;
        bus.bus_grant        = 1'b0;
        dbg_is_brk           = 1'b0;
        dbg_sp_wr            = 1'b0;
    endtask

    task automatic check_state(input string tag);
        n_checks++;
        if (sp !== m_sp[7:0]) begin n_fail++; $display("FAIL %s sp: got %h want %h", tag, sp, m_sp[7:0]); end
        n_checks++;
        if (bus.pc_pop !== m_pc_pop) begin n_fail++; $display("FAIL %s pc_pop: got %h want %h", tag, bus.pc_pop, m_pc_pop); end
        n_checks++;
        if (bus.flags_pop !== m_flags_pop) begin n_fail++; $display("FAIL %s flags_pop: got %h want %h", tag, bus.flags_pop, m_flags_pop); end
        n_checks++;
        if ({stack_ovf, stack_unf} !== {m_ovf, m_unf}) begin n_fail++; $display("FAIL %s ovf/unf: got %b%b want %b%b", tag, stack_ovf, stack_unf, m_ovf, m_unf); end
    endtask

    // One frame; stall<0 picks 0..3 random stall cycles before each access.
    task automatic run_frame(input bit push, input logic [7:0] pc, input logic [5:0] fl,
                             input int stall, input bit toggle, input bit abort, input string tag);
        logic [7:0] a0, a1;
        int ns;
        a0 = push ? m_sp[7:0] : 8'(m_sp + 1);
        a1 = push ? 8'(m_sp - 1) : 8'(m_sp + 2);
        for (int acc = 0; acc < 2; acc++) begin
            logic [7:0] ea;
            logic [7:0] ew;
            ea = (acc == 0) ? a0 : a1;
            ew = !push ? 8'h00 : (acc == 0) ? pc : {2'b00, fl};
            if (acc == 1 && abort) begin
                @(negedge clk);
                bus.stack_op_ongoing = 1'b0;
                bus.bus_grant = 1'($urandom);
                #1;
                n_checks++;
                if (bus.stack_op_end !== 1'b0) begin n_fail++; $display("FAIL %s abort end: got %b want 0", tag, bus.stack_op_end); end
                break;
            end
            ns = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
            for (int s = 0; s < ns; s++) begin
                @(negedge clk);
                bus.stack_op_ongoing = 1'b1;
                bus.bus_grant = 1'b0;
                bus.push_or_pop = (acc == 1 && toggle) ? !push : push;
                #1;
                n_checks++;
                if (bus.stack_addr !== ea || bus.stack_op_end !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s stall acc%0d addr/end: got %h/%b want %h/0", tag, acc, bus.stack_addr, bus.stack_op_end, ea);
                end
            end
            @(negedge clk);
            bus.stack_op_ongoing = 1'b1;
            bus.bus_grant = 1'b1;
            bus.push_or_pop = (acc == 1 && toggle) ? !push : push;
            bus.pc_in = pc;
            bus.flags_in = fl;
            bus.mem_din = push ? 8'($urandom) : mem[ea];
            #1;
            n_checks++;
            if (bus.stack_addr !== ea || bus.stack_wdata !== ew || bus.stack_op_end !== (acc == 1)) begin
                n_fail++;
                $display("FAIL %s acc%0d addr/wdata/end: got %h/%h/%b want %h/%h/%b", tag, acc,
                         bus.stack_addr, bus.stack_wdata, bus.stack_op_end, ea, ew, acc == 1);
            end
            if (acc == 0) begin
                if (push) begin
                    mem[ea] = pc;
                    if (m_sp - 1 < 32'h0C0) m_ovf = 1'b1;
                end else begin
                    m_flags_pop = mem[ea][5:0];
                    if (m_sp + 2 > 255) m_unf = 1'b1;
                end
            end else begin
                if (push) begin
                    mem[ea] = {2'b00, fl};
                    m_sp = (m_sp - 2) & 255;
                end else begin
                    m_pc_pop = mem[ea];
                    m_sp = (m_sp + 2) & 255;
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        bus.push_or_pop = push;
        #1;
        check_state(tag);
    endtask

    task automatic dbg_write(input logic [7:0] val);
        @(negedge clk);
        idle_inputs();
        dbg_is_brk = 1'b1;
        dbg_sp_wr  = 1'b1;
        dbg_sp_din = val;
        @(negedge clk);
        idle_inputs();
        m_sp = val;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        check_state("dbg_write");
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.push_or_pop = POP;
        bus.pc_in = 8'h00;
        bus.flags_in = 6'h00;
        bus.mem_din = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_sp = 255; m_ovf = 0; m_unf = 0; m_pc_pop = 8'h00; m_flags_pop = 6'h00;
        #1;
        check_state("reset");
        n_checks++;
        if (bus.stack_addr !== 8'h00 || bus.stack_op_end !== 1'b0) begin
            n_fail++; $display("FAIL reset idle addr/end: got %h/%b want 00/0", bus.stack_addr, bus.stack_op_end);
        end
    endtask

    task automatic test_jsr_push();
        run_frame(1'b1, 8'h3A, 6'h2D, 0, 1'b0, 1'b0, "jsr_push");
        n_checks++;
        if (sp !== 8'hFD || mem[8'hFF] !== 8'h3A || mem[8'hFE] !== 8'h2D) begin
            n_fail++; $display("FAIL jsr_push frame: sp %h want FD", sp);
        end
    endtask

    task automatic test_rts_pop();
        run_frame(1'b0, 8'h00, 6'h00, 0, 1'b0, 1'b0, "rts_pop");
        n_checks++;
        if (bus.pc_pop !== 8'h3A || bus.flags_pop !== 6'h2D || sp !== 8'hFF) begin
            n_fail++; $display("FAIL rts_pop values: got %h/%h/%h want 3A/2D/FF", bus.pc_pop, bus.flags_pop, sp);
        end
    endtask

    task automatic test_stalls();
        run_frame(1'b1, 8'h81, 6'h15, 3, 1'b0, 1'b0, "stall_push");
        run_frame(1'b0, 8'h00, 6'h00, 3, 1'b0, 1'b0, "stall_pop");
    endtask

    task automatic test_dir_toggle();
        run_frame(1'b1, 8'h44, 6'h3F, 0, 1'b1, 1'b0, "toggle_push");
        run_frame(1'b0, 8'h00, 6'h00, 1, 1'b1, 1'b0, "toggle_pop");
    endtask

    task automatic test_errors();
        run_frame(1'b0, 8'h00, 6'h00, 0, 1'b0, 1'b0, "underflow");
        n_checks++;
        if (stack_unf !== 1'b1 || sp !== 8'h01) begin
            n_fail++; $display("FAIL underflow: unf %b sp %h want 1/01", stack_unf, sp);
        end
        dbg_write(8'hC0);
        run_frame(1'b1, 8'h12, 6'h01, 0, 1'b0, 1'b0, "overflow");
        n_checks++;
        if (stack_ovf !== 1'b1 || sp !== 8'hBE) begin
            n_fail++; $display("FAIL overflow: ovf %b sp %h want 1/BE", stack_ovf, sp);
        end
        run_frame(1'b0, 8'h00, 6'h00, 0, 1'b0, 1'b0, "ovf_sticky");
        dbg_write(8'hFF);
    endtask

    task automatic test_debug_in_acc1();
        @(negedge clk);
        bus.stack_op_ongoing = 1'b1; bus.bus_grant = 1'b1;
        bus.push_or_pop = PUSH; bus.pc_in = 8'h9C; bus.flags_in = 6'h0A;
        @(negedge clk);
        bus.bus_grant = 1'b0;
        dbg_is_brk = 1'b1; dbg_sp_wr = 1'b1; dbg_sp_din = 8'h55;
        @(negedge clk);
        dbg_is_brk = 1'b0; dbg_sp_wr = 1'b0; bus.bus_grant = 1'b1;
        @(negedge clk);
        idle_inputs();
        mem[m_sp] = 8'h9C; mem[(m_sp - 1) & 255] = 8'h0A;
        m_sp = (m_sp - 2) & 255;
        #1;
        check_state("dbg_in_acc1");
    endtask

    task automatic test_rst_mid_frame();
        @(negedge clk);
        bus.stack_op_ongoing = 1'b1; bus.bus_grant = 1'b1; bus.push_or_pop = PUSH;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        m_sp = 255; m_ovf = 0; m_unf = 0; m_pc_pop = 8'h00; m_flags_pop = 6'h00;
        #1;
        check_state("rst_mid");
        n_checks++;
        if (bus.stack_op_end !== 1'b0) begin n_fail++; $display("FAIL rst_mid end: got %b want 0", bus.stack_op_end); end
        run_frame(1'b1, 8'h27, 6'h33, 0, 1'b0, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(7, 0) == 0) dbg_write(8'($urandom));
            run_frame(1'($urandom), 8'($urandom), 6'($urandom), -1,
                      ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_jsr_push();
        test_rts_pop();
        test_stalls();
        test_dir_toggle();
        test_errors();
        test_debug_in_acc1();
        test_rst_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
